// File: rtl/fsm_responder_pkg.sv
// Shared encodings and default widths for the fsm_responder worker.
// Imported by fsm_responder and countdown_reg.
package fsm_responder_pkg;

   localparam int LEN_W_DEF   = 8;
   localparam int JOBS_W_DEF  = 16;
   localparam int STATE_W_DEF = 8;

   localparam logic [STATE_W_DEF-1:0] ST_IDLE = 8'd0;
   localparam logic [STATE_W_DEF-1:0] ST_RUN  = 8'd1;
   localparam logic [STATE_W_DEF-1:0] ST_DONE = 8'd2;

endpackage

// File: rtl/countdown_reg.sv
// Loadable down-counter for the job length; one_hit flags the final RUN cycle.
module countdown_reg
   import fsm_responder_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [LEN_W-1:0] load_value,
   output logic [LEN_W-1:0] value,
   output logic             one_hit
);

   logic [LEN_W-1:0] count_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (en) begin
         count_reg <= count_reg - LEN_W'(1);
      end
   end

   assign value   = count_reg;
   assign one_hit = (count_reg == LEN_W'(1));

endmodule

// File: rtl/fsm_responder.sv
// Worker end of the start/done handshake: counts a job of length len, then pulses done.
// Optional sticky overrun output enabled by defining FSM_RESPONDER_OVERRUN_EN.
module fsm_responder
   import fsm_responder_pkg::*;
#(
   parameter int LEN_W   = LEN_W_DEF,
   parameter int JOBS_W  = JOBS_W_DEF,
   parameter int STATE_W = STATE_W_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [LEN_W-1:0]   len,
   output logic               done,
   output logic               busy,
   output logic [STATE_W-1:0] state,
   output logic [JOBS_W-1:0]  jobs
`ifdef FSM_RESPONDER_OVERRUN_EN
   ,
   output logic               overrun
`endif
);

   localparam logic [STATE_W-1:0] S_IDLE = STATE_W'(ST_IDLE);
   localparam logic [STATE_W-1:0] S_RUN  = STATE_W'(ST_RUN);
   localparam logic [STATE_W-1:0] S_DONE = STATE_W'(ST_DONE);

   logic [STATE_W-1:0] state_reg;
   logic [JOBS_W-1:0]  jobs_reg;
   logic [LEN_W-1:0]   count_value;
   logic               count_one;
   logic               count_load;
   logic               count_en;
   logic               len_nonzero;

   assign len_nonzero = (len != '0);
   assign count_load  = (state_reg == S_IDLE) && start && len_nonzero;
   assign count_en    = (state_reg == S_RUN);

   countdown_reg #(
      .LEN_W(LEN_W)
   ) u_countdown (
      .clock      (clock),
      .reset      (reset),
      .load       (count_load),
      .en         (count_en),
      .load_value (len),
      .value      (count_value),
      .one_hit    (count_one)
   );

   // A zero count in RUN can only follow a corrupted state; leave rather than wrap for 2^LEN_W cycles.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         jobs_reg  <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_reg <= len_nonzero ? S_RUN : S_DONE;
               end
            end
            S_RUN: begin
               if (count_one || (count_value == '0)) begin
                  state_reg <= S_DONE;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
               jobs_reg  <= jobs_reg + JOBS_W'(1);
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

`ifdef FSM_RESPONDER_OVERRUN_EN
   logic overrun_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overrun_reg <= 1'b0;
      end else if (start && ((state_reg == S_RUN) || (state_reg == S_DONE))) begin
         overrun_reg <= 1'b1;
      end
   end

   assign overrun = overrun_reg;
`endif

   assign state = state_reg;
   assign jobs  = jobs_reg;
   assign done  = (state_reg == S_DONE);
   assign busy  = (state_reg != S_IDLE);

endmodule

// File: tb/tb_fsm_responder.sv
// Directed bench for fsm_responder; a second narrow instance exercises jobs wrap cheaply.
module tb_fsm_responder;

   logic        clock;
   logic        reset;
   logic        start;
   logic [7:0]  len;
   logic        done;
   logic        busy;
   logic [7:0]  state;
   logic [15:0] jobs;
`ifdef FSM_RESPONDER_OVERRUN_EN
   logic        overrun;
   logic        s_overrun;
`endif

   logic        s_start;
   logic [3:0]  s_len;
   logic        s_done;
   logic        s_busy;
   logic [7:0]  s_state;
   logic [3:0]  s_jobs;

   int vectors;
   int miscompares;

   fsm_responder dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .len     (len),
      .done    (done),
      .busy    (busy),
      .state   (state),
`ifdef FSM_RESPONDER_OVERRUN_EN
      .overrun (overrun),
`endif
      .jobs    (jobs)
   );

   fsm_responder #(
      .LEN_W  (4),
      .JOBS_W (4)
   ) dut_small (
      .clock   (clock),
      .reset   (reset),
      .start   (s_start),
      .len     (s_len),
      .done    (s_done),
      .busy    (s_busy),
      .state   (s_state),
`ifdef FSM_RESPONDER_OVERRUN_EN
      .overrun (s_overrun),
`endif
      .jobs    (s_jobs)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int cnt;
      int done_seen;
      logic [7:0] exp_state;

      vectors     = 0;
      miscompares = 0;
      reset   = 1'b1;
      start   = 1'b0;
      len     = 8'd0;
      s_start = 1'b0;
      s_len   = 4'd0;

      // Reset held for two edges, then released
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rst_state", 32'(state), 32'd0);
      check("rst_done",  32'(done),  32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_jobs",  32'(jobs),  32'd0);
`ifdef FSM_RESPONDER_OVERRUN_EN
      check("rst_overrun", 32'(overrun), 32'd0);
`endif

      // Single job, len=3
      start = 1'b1;
      len   = 8'd3;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         check($sformatf("job3_state_s%0d", k), 32'(state), 32'd1);
         check($sformatf("job3_busy_s%0d", k),  32'(busy),  32'd1);
         check($sformatf("job3_done_s%0d", k),  32'(done),  32'd0);
         tick();
      end
      check("job3_state_s4", 32'(state), 32'd2);
      check("job3_done_s4",  32'(done),  32'd1);
      check("job3_jobs_s4",  32'(jobs),  32'd0);
      tick();
      check("job3_state_s5", 32'(state), 32'd0);
      check("job3_done_s5",  32'(done),  32'd0);
      check("job3_jobs_s5",  32'(jobs),  32'd1);

      // Zero-length job
      start = 1'b1;
      len   = 8'd0;
      tick();
      start = 1'b0;
      check("len0_state", 32'(state), 32'd2);
      check("len0_done",  32'(done),  32'd1);
      tick();
      check("len0_idle", 32'(state), 32'd0);
      check("len0_jobs", 32'(jobs),  32'd2);

      // start held high with len=2: accepted at steps 0, 4, 8
      start = 1'b1;
      len   = 8'd2;
      for (int s = 1; s <= 9; s++) begin
         tick();
         case (s % 4)
            0:       exp_state = 8'd0;
            3:       exp_state = 8'd2;
            default: exp_state = 8'd1;
         endcase
         check($sformatf("hold_state_s%0d", s), 32'(state), 32'(exp_state));
`ifdef FSM_RESPONDER_OVERRUN_EN
         check($sformatf("hold_overrun_s%0d", s), 32'(overrun), (s >= 2) ? 32'd1 : 32'd0);
`endif
      end
      check("hold_jobs_s9", 32'(jobs), 32'd4);
      start = 1'b0;
      tick();
      tick();
      tick();
      check("hold_drain_state", 32'(state), 32'd0);
      check("hold_drain_jobs",  32'(jobs),  32'd5);
`ifdef FSM_RESPONDER_OVERRUN_EN
      check("hold_overrun_sticky", 32'(overrun), 32'd1);
`endif

      // Maximum length: done exactly 256 cycles after acceptance
      start = 1'b1;
      len   = 8'd255;
      tick();
      start = 1'b0;
      cnt = 1;
      while (!done && cnt < 400) begin
         tick();
         cnt++;
      end
      check("max_len_latency", 32'(cnt), 32'd256);
      tick();
      check("max_len_jobs", 32'(jobs), 32'd6);

      // Asynchronous reset in the middle of RUN
      start = 1'b1;
      len   = 8'd10;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("abort_pre_state", 32'(state), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("abort_state", 32'(state), 32'd0);
      check("abort_busy",  32'(busy),  32'd0);
      check("abort_done",  32'(done),  32'd0);
      check("abort_jobs",  32'(jobs),  32'd0);
`ifdef FSM_RESPONDER_OVERRUN_EN
      check("abort_overrun", 32'(overrun), 32'd0);
`endif
      #2;
      reset = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (done) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      check("abort_jobs_after", 32'(jobs), 32'd0);

      // Narrow instance: len=15 full range, then jobs wrap 0xF -> 0x0
      s_start = 1'b1;
      s_len   = 4'd15;
      tick();
      s_start = 1'b0;
      cnt = 1;
      while (!s_done && cnt < 40) begin
         tick();
         cnt++;
      end
      check("small_max_latency", 32'(cnt), 32'd16);
      tick();
      s_len = 4'd0;
      for (int j = 0; j < 14; j++) begin
         s_start = 1'b1;
         tick();
         s_start = 1'b0;
         tick();
      end
      check("small_jobs_15", 32'(s_jobs), 32'd15);
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      tick();
      check("small_jobs_wrap", 32'(s_jobs), 32'd0);
      check("small_wrap_state", 32'(s_state), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
